// File: rtl/esn_pe_pkg.sv
// rtl/esn_pe_pkg.sv - shared widths, Q10.21 limits and signed saturating clamp
package esn_pe_pkg;

    localparam int WWORD_LEN = 32;
    localparam int SWORD_LEN = 16;
    localparam int NPSUM     = 8;
    localparam int ACC_LEN   = 48;

    localparam logic [31:0] QMAX = 32'h7FFF_FFFF;
    localparam logic [31:0] QMIN = 32'h8000_0000;

    // Clamp x to the signed range of a w-bit word; sat reports whether it clipped.
    function automatic logic signed [63:0] sat_clamp(
        input  logic signed [63:0] x,
        input  int                 w,
        output logic               sat
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        sat = 1'b1;
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end
        sat = 1'b0;
        return x;
    endfunction

endpackage

// File: rtl/psum_add_tree.sv
// rtl/psum_add_tree.sv - registered pairwise adder tree with valid/last sideband
module psum_add_tree #(
    parameter  int WWORD_LEN = esn_pe_pkg::WWORD_LEN,
    parameter  int NPSUM     = esn_pe_pkg::NPSUM,
    localparam int LEVELS    = $clog2(NPSUM),
    localparam int SUM_W     = WWORD_LEN + LEVELS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ce,
    input  logic                          in_valid,
    input  logic                          in_last,
    input  logic [NPSUM*WWORD_LEN-1:0]    in_psum,
    output logic                          sum_valid,
    output logic                          sum_last,
    output logic signed [SUM_W-1:0]       sum
);

    // Every level uses the final width; the exact sum never needs more.
    logic signed [SUM_W-1:0] node_d [LEVELS][NPSUM/2];
    logic signed [SUM_W-1:0] node_q [LEVELS][NPSUM/2];
    logic [LEVELS-1:0]       valid_d, valid_q;
    logic [LEVELS-1:0]       last_d,  last_q;

    always_comb begin
        node_d  = node_q;
        valid_d = valid_q;
        last_d  = last_q;
        if (ce) begin
            valid_d[0] = in_valid;
            last_d[0]  = in_valid && in_last;
            for (int i = 0; i < NPSUM / 2; i++) begin
                node_d[0][i] = SUM_W'(signed'(in_psum[(2*i+1)*WWORD_LEN-1 -: WWORD_LEN]))
                             + SUM_W'(signed'(in_psum[(2*i+2)*WWORD_LEN-1 -: WWORD_LEN]));
            end
            for (int l = 1; l < LEVELS; l++) begin
                valid_d[l] = valid_q[l-1];
                last_d[l]  = last_q[l-1];
                for (int i = 0; i < (NPSUM >> (l + 1)); i++) begin
                    node_d[l][i] = node_q[l-1][2*i] + node_q[l-1][2*i+1];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            node_q  <= '{default: '0};
            valid_q <= '0;
            last_q  <= '0;
        end else begin
            node_q  <= node_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign sum_valid = valid_q[LEVELS-1];
    assign sum_last  = last_q[LEVELS-1];
    assign sum       = node_q[LEVELS-1][0];

endmodule

// File: rtl/pe_psum_accum.sv
// rtl/pe_psum_accum.sv - reduces PE partial sums per beat and accumulates a vector readout
module pe_psum_accum #(
    parameter int WWORD_LEN = esn_pe_pkg::WWORD_LEN,
    parameter int NPSUM     = esn_pe_pkg::NPSUM,
    parameter int ACC_LEN   = esn_pe_pkg::ACC_LEN,
    parameter int CNT_LEN   = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ce,
    input  logic                        in_valid,
    input  logic                        in_last,
    input  logic [NPSUM*WWORD_LEN-1:0]  in_psum,
    output logic                        out_valid,
    output logic [WWORD_LEN-1:0]        out_q,
    output logic                        out_sat,
    output logic [CNT_LEN-1:0]          out_beats
);
    import esn_pe_pkg::*;

    localparam int                 TREE_W  = WWORD_LEN + $clog2(NPSUM);
    localparam logic [CNT_LEN-1:0] CNT_MAX = '1;

    logic                     sum_valid, sum_last;
    logic signed [TREE_W-1:0] sum;

    psum_add_tree #(
        .WWORD_LEN (WWORD_LEN),
        .NPSUM     (NPSUM)
    ) u_tree (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_psum   (in_psum),
        .sum_valid (sum_valid),
        .sum_last  (sum_last),
        .sum       (sum)
    );

    logic signed [ACC_LEN-1:0] acc_d, acc_q;
    logic [CNT_LEN-1:0]        cnt_d, cnt_q;
    logic                      sticky_d, sticky_q;
    logic                      first_d, first_q;
    logic                      out_valid_d, out_valid_q;
    logic [WWORD_LEN-1:0]      out_q_d, out_q_q;
    logic                      out_sat_d, out_sat_q;
    logic [CNT_LEN-1:0]        out_beats_d, out_beats_q;

    logic signed [63:0]        acc_wide, out_wide;
    logic signed [ACC_LEN-1:0] acc_next;
    logic                      acc_clamp, out_clamp;
    logic [CNT_LEN-1:0]        cnt_next;

    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        sticky_d    = sticky_q;
        first_d     = first_q;
        out_valid_d = out_valid_q;
        out_q_d     = out_q_q;
        out_sat_d   = out_sat_q;
        out_beats_d = out_beats_q;

        acc_wide = sat_clamp((first_q ? 64'sd0 : 64'(acc_q)) + 64'(sum), ACC_LEN, acc_clamp);
        acc_next = ACC_LEN'(acc_wide);
        cnt_next = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_LEN'(1);
        out_wide = sat_clamp(64'(acc_next), WWORD_LEN, out_clamp);

        if (ce) begin
            out_valid_d = 1'b0;
            if (sum_valid) begin
                acc_d    = acc_next;
                sticky_d = sticky_q | acc_clamp;
                cnt_d    = cnt_next;
                first_d  = 1'b0;
                // The closing beat publishes and rearms in the same cycle, so a
                // new vector can start on the very next beat without a bubble.
                if (sum_last) begin
                    out_valid_d = 1'b1;
                    out_q_d     = WWORD_LEN'(out_wide);
                    out_sat_d   = sticky_q | acc_clamp | out_clamp;
                    out_beats_d = cnt_next;
                    sticky_d    = 1'b0;
                    cnt_d       = '0;
                    first_d     = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            sticky_q    <= 1'b0;
            first_q     <= 1'b1;
            out_valid_q <= 1'b0;
            out_q_q     <= '0;
            out_sat_q   <= 1'b0;
            out_beats_q <= '0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sticky_q    <= sticky_d;
            first_q     <= first_d;
            out_valid_q <= out_valid_d;
            out_q_q     <= out_q_d;
            out_sat_q   <= out_sat_d;
            out_beats_q <= out_beats_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_q     = out_q_q;
    assign out_sat   = out_sat_q;
    assign out_beats = out_beats_q;

endmodule

// File: tb/tb_pe_psum_accum.sv
// tb/tb_pe_psum_accum.sv - directed self-checking bench for pe_psum_accum
module tb_pe_psum_accum;

    logic         clk = 1'b0;
    logic         rst;
    logic         ce;
    logic         in_valid;
    logic         in_last;
    logic [255:0] in_psum;
    logic         out_valid;
    logic [31:0]  out_q;
    logic         out_sat;
    logic [7:0]   out_beats;

    int errors = 0;
    int checks = 0;

    pe_psum_accum dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_psum   (in_psum),
        .out_valid (out_valid),
        .out_q     (out_q),
        .out_sat   (out_sat),
        .out_beats (out_beats)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [31:0] p, input logic last);
        in_psum  = {8{p}};
        in_valid = 1'b1;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Called right after the closing beat's acceptance edge; result due 3 edges later.
    task automatic finish_vec(input string tag, input logic [31:0] q, input logic sat,
                              input logic [7:0] beats);
        tick();
        chk({tag, "_early1"}, 64'(out_valid), 64'd0);
        tick();
        chk({tag, "_early2"}, 64'(out_valid), 64'd0);
        tick();
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_q"}, 64'(out_q), 64'(q));
        chk({tag, "_sat"}, 64'(out_sat), 64'(sat));
        chk({tag, "_beats"}, 64'(out_beats), 64'(beats));
        tick();
        chk({tag, "_pulse"}, 64'(out_valid), 64'd0);
        chk({tag, "_qhold"}, 64'(out_q), 64'(q));
    endtask

    initial begin
        rst      = 1'b1;
        ce       = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_psum  = '0;
        tick();
        tick();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_q", 64'(out_q), 64'd0);
        chk("rst_sat", 64'(out_sat), 64'd0);
        chk("rst_beats", 64'(out_beats), 64'd0);
        rst = 1'b0;
        ce  = 1'b1;
        tick();

        // eight 1.0 -> 8.0
        beat(32'h0020_0000, 1'b1);
        finish_vec("single", 32'h0100_0000, 1'b0, 8'd1);

        // four beats of eight 1 LSB -> 32 LSB
        for (int b = 0; b < 3; b++) beat(32'h0000_0001, 1'b0);
        beat(32'h0000_0001, 1'b1);
        finish_vec("multi", 32'h0000_0020, 1'b0, 8'd4);

        beat(32'h7FFF_FFFF, 1'b1);
        finish_vec("sat_pos", 32'h7FFF_FFFF, 1'b1, 8'd1);
        beat(32'h8000_0000, 1'b1);
        finish_vec("sat_neg", 32'h8000_0000, 1'b1, 8'd1);
        beat(32'h0000_0001, 1'b1);
        finish_vec("sat_clear", 32'h0000_0008, 1'b0, 8'd1);

        // 260 zero beats: counter pins at 255
        for (int b = 0; b < 259; b++) beat(32'h0000_0000, 1'b0);
        beat(32'h0000_0000, 1'b1);
        finish_vec("cnt_sat", 32'h0000_0000, 1'b0, 8'd255);

        // stall 3 cycles while the closing beat is in flight
        for (int b = 0; b < 3; b++) beat(32'h0000_0001, 1'b0);
        beat(32'h0000_0001, 1'b1);
        tick();
        ce = 1'b0;
        for (int s = 0; s < 3; s++) begin
            tick();
            chk("stall_frozen", 64'(out_valid), 64'd0);
        end
        ce = 1'b1;
        tick();
        chk("stall_early", 64'(out_valid), 64'd0);
        tick();
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_q", 64'(out_q), 64'h20);
        chk("stall_beats", 64'(out_beats), 64'd4);
        ce = 1'b0;
        tick();
        chk("stall_hold_valid", 64'(out_valid), 64'd1);
        ce = 1'b1;
        tick();
        chk("stall_release", 64'(out_valid), 64'd0);

        // in_last without in_valid must not close anything
        in_last = 1'b1;
        for (int s = 0; s < 5; s++) begin
            tick();
            chk("stray_last", 64'(out_valid), 64'd0);
        end
        in_last = 1'b0;

        // reset after 2 of 4 beats discards them
        beat(32'h0000_0001, 1'b0);
        beat(32'h0000_0001, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_valid", 64'(out_valid), 64'd0);
        beat(32'h0000_0002, 1'b1);
        finish_vec("midrst_next", 32'h0000_0010, 1'b0, 8'd1);

        // back-to-back single-beat vectors: +8, -8, 0
        beat(32'h0000_0001, 1'b1);
        beat(32'hFFFF_FFFF, 1'b1);
        beat(32'h0000_0000, 1'b1);
        tick();
        chk("b2b0_valid", 64'(out_valid), 64'd1);
        chk("b2b0_q", 64'(out_q), 64'h0000_0008);
        tick();
        chk("b2b1_valid", 64'(out_valid), 64'd1);
        chk("b2b1_q", 64'(out_q), 64'hFFFF_FFF8);
        chk("b2b1_beats", 64'(out_beats), 64'd1);
        tick();
        chk("b2b2_valid", 64'(out_valid), 64'd1);
        chk("b2b2_q", 64'(out_q), 64'h0000_0000);
        chk("b2b2_sat", 64'(out_sat), 64'd0);
        tick();
        chk("b2b_end", 64'(out_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
